// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
//
// Purpose: turns the single-cycle CPU datapath's data-memory access
// (ALU result as address, register-file store data, MemRead/MemWrite) into
// a req/ack transaction toward a variable-latency data memory, and stalls
// the CPU (PC hold, RegWrite suppression) until that transaction completes.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   cpu_addr_i           byte address from the ALU
//   cpu_wdata_i          store data from the register file
//   cpu_memread_i        load request
//   cpu_memwrite_i       store request (wins when both are high)
//   cpu_rdata_o          load data, valid in the DONE cycle, held otherwise
//   cpu_stall_o          CPU must hold PC and suppress RegWrite while high
//   misalign_o           one-cycle pulse after a non-word-aligned request
//   timeout_o            one-cycle pulse (with DONE) on an aborted access
//   mem_req_o            bus request level, high exactly while in REQ
//   mem_we_o             1 = write, 0 = read
//   mem_addr_o           registered address
//   mem_wdata_o          registered store data
//   mem_ack_i            bus completion, one-cycle pulse
//   mem_rdata_i          read data, valid with mem_ack_i
//   dbg_state            current FSM state (IDLE=0, REQ=1, DONE=2)
//
// Handshake: mem_req_o rises on the edge after an aligned request is seen in
// IDLE and stays high, with address/data/we stable, until the edge at which
// mem_ack_i is sampled high. The ack may arrive in the very first REQ cycle.
// An ack sampled in any other state is ignored.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a REQ that sees no ack
// for TIMEOUT_CYCLES cycles; the abort returns ERR_DATA and pulses timeout_o.

module dmem_bus_bridge #(
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              cpu_memread_i,
  input  logic              cpu_memwrite_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              misalign_o,
  output logic              timeout_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic cpu_req;
  logic aligned;
  logic timeout_hit;

  assign cpu_req = cpu_memread_i | cpu_memwrite_i;
  assign aligned = (cpu_addr_i[1:0] == 2'b00);

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  // Counts REQ cycles that passed without an ack; the abort fires in the
  // cycle that would make the count reach TIMEOUT_CYCLES. Ack has priority.
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  assign timeout_hit = (state_q == REQ) && !mem_ack_i &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_hit;
      if (state_q != REQ) begin
        wait_cnt <= '0;
      end else if (!mem_ack_i) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // Next-state logic and combinational outputs.
  always_comb begin
    state_d     = state_q;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && aligned) begin
          state_d     = REQ;
          cpu_stall_o = 1'b1;
        end
      end
      REQ: begin
        mem_req_o   = 1'b1;
        cpu_stall_o = 1'b1;
        if (mem_ack_i || timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Release cycle: whatever request is still present belongs to the
        // instruction being released, so it is not restarted.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      cpu_rdata_o <= '0;
      misalign_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            if (aligned) begin
              mem_addr_o  <= cpu_addr_i;
              mem_wdata_o <= cpu_wdata_i;
              mem_we_o    <= cpu_memwrite_i;
            end else begin
              // Misaligned: no bus cycle, the CPU proceeds with zero data.
              misalign_o  <= 1'b1;
              cpu_rdata_o <= '0;
            end
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            if (!mem_we_o) begin
              cpu_rdata_o <= mem_rdata_i;
            end
          end else if (timeout_hit) begin
            cpu_rdata_o <= ERR_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge
//
// Bench for dmem_bus_bridge: reset checks, a table of directed accesses,
// hand-written reset-mid-REQ and stall/timeout sequences, and randomized
// accesses checked against a transaction-level reference model.

module tb_dmem_bus_bridge;

  localparam int W   = 32;
  localparam int TO  = 16;
  localparam int BUDGET = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] cpu_addr = '0;
  logic [W-1:0] cpu_wdata = '0;
  logic         cpu_memread = 1'b0;
  logic         cpu_memwrite = 1'b0;
  logic [W-1:0] cpu_rdata;
  logic         cpu_stall;
  logic         misalign;
  logic         timeout;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_ack = 1'b0;
  logic [W-1:0] mem_rdata = '0;
  logic [1:0]   dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_bus_bridge #(.DATA_W(W), .TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cpu_addr_i    (cpu_addr),
    .cpu_wdata_i   (cpu_wdata),
    .cpu_memread_i (cpu_memread),
    .cpu_memwrite_i(cpu_memwrite),
    .cpu_rdata_o   (cpu_rdata),
    .cpu_stall_o   (cpu_stall),
    .misalign_o    (misalign),
    .timeout_o     (timeout),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_ack_i     (mem_ack),
    .mem_rdata_i   (mem_rdata),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_rdata = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int           stall;
    int           req_rises;
    int           mis;
    int           tmo;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    logic [W-1:0] final_rdata;
  } obs_t;

  typedef struct {
    int           stall;
    int           req_rises;
    int           mis;
    int           tmo;
    logic         we;
    logic [W-1:0] rdata;
  } exp_t;

  typedef struct {
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic         rd;
    logic         wr;
    int           ack_dly;
    logic [W-1:0] ack_data;
    int           e_stall;
    int           e_req;
    int           e_mis;
    logic         e_we;
    logic [W-1:0] e_rdata;
  } vec_t;

  // Reference model: one CPU access at transaction level.
  // Misaligned -> no bus cycle, misalign pulse, data 0.
  // Aligned    -> one bus cycle; stall = ack position + 1; loads return the
  //               bus data, stores leave the CPU data untouched; with the
  //               timeout enabled a missing ack aborts after TO REQ cycles.
  function automatic exp_t model(input logic [W-1:0] addr, input logic rd, input logic wr,
                                 input int ack_dly, input logic [W-1:0] ack_data);
    exp_t e;
    e.stall = 0; e.req_rises = 0; e.mis = 0; e.tmo = 0;
    e.we = wr; e.rdata = model_rdata;
    if (rd || wr) begin
      if (addr % 4 != 0) begin
        e.mis   = 1;
        e.rdata = '0;
      end else begin
        e.req_rises = 1;
`ifdef DMEM_TIMEOUT_EN
        if (ack_dly == 0 || ack_dly > TO) begin
          e.stall = TO + 1;
          e.tmo   = 1;
          e.rdata = 32'hDEAD_BEEF;
        end else
`endif
        begin
          e.stall = ack_dly + 1;
          if (!wr) e.rdata = ack_data;
        end
      end
    end
    model_rdata = e.rdata;
    return e;
  endfunction

  // ---------------- driver ----------------
  // Starts just after a rising edge. The CPU holds its request while stalled
  // and through the release cycle, then drops it; three trailing idle cycles
  // carry random stray acks, which must have no effect.
  task automatic access(input logic [W-1:0] addr, input logic [W-1:0] wdata,
                        input logic rd, input logic wr, input int ack_dly,
                        input logic [W-1:0] ack_data, output obs_t o);
    bit held, nxt_held, prev_stall, prev_req;
    int reqn, trail, c;
    o.stall = 0; o.req_rises = 0; o.mis = 0; o.tmo = 0; o.we = 1'b0;
    o.addr = '0; o.wdata = '0; o.rdata = 'x; o.final_rdata = 'x;
    cpu_addr = addr; cpu_wdata = wdata; cpu_memread = rd; cpu_memwrite = wr;
    held = 1; prev_stall = 0; prev_req = 0; reqn = 0; trail = 0; c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (cpu_stall) o.stall++;
      if (mem_req && !prev_req) begin
        o.req_rises++;
        if (o.req_rises == 1) begin
          o.we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
        end
      end
      if (mem_req) reqn++;
      if (misalign) begin o.mis++; o.rdata = cpu_rdata; end
      if (timeout) o.tmo++;
      if (prev_stall && !cpu_stall) o.rdata = cpu_rdata;
      o.final_rdata = cpu_rdata;
      if (!held) begin
        trail++;
        if ($urandom_range(0, 1) == 1) begin mem_ack = 1'b1; mem_rdata = $urandom; end
      end else if (mem_req && ack_dly > 0 && reqn == ack_dly) begin
        mem_ack = 1'b1; mem_rdata = ack_data;
      end
      nxt_held   = held && cpu_stall;
      prev_stall = cpu_stall;
      prev_req   = mem_req;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (!nxt_held) begin
        cpu_memread = 1'b0; cpu_memwrite = 1'b0; cpu_addr = $urandom;
      end
      held = nxt_held;
      if (trail >= 3) break;
      if (c >= BUDGET) begin
        check("access_budget", 32'(c), 32'(BUDGET - 1));
        break;
      end
    end
  endtask

  task automatic check_access(input string tag, input obs_t o, input exp_t e,
                              input logic [W-1:0] addr, input logic [W-1:0] wdata);
    logic [W-1:0] exp_rd;
    exp_rd = exp_q.pop_front();
    check({tag, "_stall"}, 32'(o.stall), 32'(e.stall));
    check({tag, "_req_rises"}, 32'(o.req_rises), 32'(e.req_rises));
    check({tag, "_misalign"}, 32'(o.mis), 32'(e.mis));
    check({tag, "_timeout"}, 32'(o.tmo), 32'(e.tmo));
    check({tag, "_rdata"}, o.rdata, exp_rd);
    check({tag, "_rdata_hold"}, o.final_rdata, exp_rd);
    if (e.req_rises > 0) begin
      check({tag, "_we"}, 32'(o.we), 32'(e.we));
      check({tag, "_addr"}, o.addr, addr);
      if (e.we) check({tag, "_wdata"}, o.wdata, wdata);
    end
  endtask

  task automatic run_model(input string tag, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                           input logic rd, input logic wr, input int ack_dly,
                           input logic [W-1:0] ack_data);
    exp_t e;
    obs_t o;
    e = model(addr, rd, wr, ack_dly, ack_data);
    exp_q.push_back(e.rdata);
    access(addr, wdata, rd, wr, ack_dly, ack_data, o);
    check_access(tag, o, e, addr, wdata);
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];

  initial begin
    exp_t e;
    obs_t o;
    int   n;
    logic [W-1:0] a;
    logic [1:0]   sel;

    vecs[0] = '{32'h10, 32'h0, 1'b1, 1'b0, 2, 32'h1234_5678, 3, 1, 0, 1'b0, 32'h1234_5678};
    vecs[1] = '{32'h20, 32'hCAFE_F00D, 1'b0, 1'b1, 1, 32'h9999_9999, 2, 1, 0, 1'b1, 32'h1234_5678};
    vecs[2] = '{32'h13, 32'h0, 1'b1, 1'b0, 1, 32'h0, 0, 0, 1, 1'b0, 32'h0};
    vecs[3] = '{32'h08, 32'h55AA_55AA, 1'b1, 1'b1, 3, 32'h1111_1111, 4, 1, 0, 1'b1, 32'h0};
    vecs[4] = '{32'h04, 32'h0, 1'b1, 1'b0, 1, 32'hA5A5_0001, 2, 1, 0, 1'b0, 32'hA5A5_0001};
    vecs[5] = '{32'h22, 32'h7777_0000, 1'b0, 1'b1, 1, 32'h0, 0, 0, 1, 1'b1, 32'h0};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 5, 32'h0BAD_F00D, 6, 1, 0, 1'b0, 32'h0BAD_F00D};
    vecs[7] = '{32'h31, 32'h1, 1'b1, 1'b1, 1, 32'h0, 0, 0, 1, 1'b1, 32'h0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rdata", cpu_rdata, '0);
    check("rst_stall", 32'(cpu_stall), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_addr", mem_addr, '0);
    check("rst_wdata", mem_wdata, '0);
    check("rst_misalign", 32'(misalign), 0);
    check("rst_timeout", 32'(timeout), 0);
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      e.stall = vecs[i].e_stall; e.req_rises = vecs[i].e_req; e.mis = vecs[i].e_mis;
      e.tmo = 0; e.we = vecs[i].e_we; e.rdata = vecs[i].e_rdata;
      exp_q.push_back(vecs[i].e_rdata);
      model_rdata = vecs[i].e_rdata;
      access(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr, vecs[i].ack_dly,
             vecs[i].ack_data, o);
      check_access($sformatf("vec%0d", i), o, e, vecs[i].addr, vecs[i].wdata);
    end

    // Reset during the third REQ cycle; a late ack must be ignored.
    cpu_addr = 32'h40; cpu_wdata = '0; cpu_memread = 1'b1; cpu_memwrite = 1'b0;
    @(negedge clk);
    check("mid_rst_idle_stall", 32'(cpu_stall), 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_req_before", 32'(mem_req), 1);
    rst = 1'b1; cpu_memread = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_req_after", 32'(mem_req), 0);
    check("mid_rst_stall_after", 32'(cpu_stall), 0);
    check("mid_rst_rdata_after", cpu_rdata, '0);
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req", 32'(mem_req), 0);
    check("late_ack_stall", 32'(cpu_stall), 0);
    check("late_ack_rdata", cpu_rdata, '0);
    model_rdata = '0;
    @(posedge clk); #1;

`ifdef DMEM_TIMEOUT_EN
    // Abort with no ack, ack exactly at the limit, ack one past the limit.
    run_model("tmo_noack", 32'h50, 32'h0, 1'b1, 1'b0, 0, 32'h0);
    run_model("tmo_ack_at_limit", 32'h54, 32'h0, 1'b1, 1'b0, TO, 32'h600D_0016);
    run_model("tmo_store_abort", 32'h58, 32'h1234_0000, 1'b0, 1'b1, TO + 1, 32'h0);
`else
    // Without the timeout an unacknowledged access stalls indefinitely.
    cpu_addr = 32'h80; cpu_memread = 1'b1; cpu_memwrite = 1'b0;
    n = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (cpu_stall && mem_req === (i > 0)) n++;
      @(posedge clk); #1;
    end
    check("no_timeout_stall_120", 32'(n), 120);
    check("no_timeout_pulse", 32'(timeout), 0);
    rst = 1'b1; cpu_memread = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    model_rdata = '0;
`endif

    // Randomized accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      sel = 2'($urandom_range(1, 3));
`ifdef DMEM_TIMEOUT_EN
      n = $urandom_range(0, 20);
`else
      n = $urandom_range(1, 6);
`endif
      run_model($sformatf("rnd%0d", i), a, $urandom, sel[0], sel[1], n, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
- Sits directly downstream of the single-cycle CPU datapath. Consumes the ALU result as address, the register-file store data, and the MemRead/MemWrite controls.
- Converts the CPU's one-cycle memory access into a req/ack handshake toward a variable-latency data memory.
- Holds the CPU with a stall signal until the access completes. The stall freezes the PC and register-file write enable.

Parameters:
- DATA_W, 32, data and address width in bits.
- TIMEOUT_CYCLES, 16, cycles spent in REQ without an ack before abort (used only with DMEM_TIMEOUT_EN).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on abort.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_addr_i  in  DATA_W  byte address (ALU result).
- cpu_wdata_i  in  DATA_W  store data.
- cpu_memread_i  in  1  load request.
- cpu_memwrite_i  in  1  store request.
- cpu_rdata_o  out  DATA_W  load data, valid in the DONE cycle.
- cpu_stall_o  out  1  CPU must hold PC and suppress RegWrite while high.
- misalign_o  out  1  one-cycle pulse on a non-word-aligned request.
- timeout_o  out  1  one-cycle pulse on an aborted access.
- mem_req_o  out  1  bus request, level.
- mem_we_o  out  1  1 = write, 0 = read.
- mem_addr_o  out  DATA_W  registered address.
- mem_wdata_o  out  DATA_W  registered store data.
- mem_ack_i  in  1  bus completion, one-cycle pulse.
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i.

Behaviour:
- States: IDLE, REQ, DONE. Two-bit state register; all registers update only on the clk_i rising edge.
- Reset (rst_i=1 at an edge):
  - state goes to IDLE.
  - mem_req_o, mem_we_o, misalign_o and timeout_o go to 0.
  - mem_addr_o, mem_wdata_o and cpu_rdata_o go to 0.
  - The timeout counter goes to 0.
  - Reset mid-transaction drops mem_req_o on the next edge without waiting for ack; a late ack is ignored in IDLE.
- Request in IDLE: req = cpu_memread_i | cpu_memwrite_i.
  - If both are high, the request is a write (write priority).
- IDLE, req with cpu_addr_i[1:0]==0:
  - Latch address, wdata and we (= cpu_memwrite_i).
  - Next state REQ.
  - cpu_stall_o is asserted combinationally in this same cycle.
- IDLE, req with cpu_addr_i[1:0]!=0:
  - No bus transaction; stay in IDLE.
  - misalign_o=1 for the next cycle.
  - cpu_rdata_o=0; cpu_stall_o stays 0 so the CPU proceeds.
- REQ:
  - mem_req_o=1 and cpu_stall_o=1.
  - Address, data and we are held stable.
  - On mem_ack_i=1: drop req, capture mem_rdata_i into cpu_rdata_o if a read (hold the previous value if a write), next state DONE.
  - An ack in the first REQ cycle is legal, giving a minimum 2-cycle stall.
- DONE:
  - cpu_stall_o=0 for exactly one cycle; cpu_rdata_o is valid for the CPU writeback.
  - Next state is IDLE unconditionally.
  - Any request present in DONE belongs to the instruction being released and is NOT restarted.
- cpu_stall_o = (IDLE & req & aligned) | REQ.
- Total stall for an ack arriving N cycles after REQ entry = N+1 cycles; the DONE cycle is the release.
- cpu_rdata_o holds its value outside DONE.
- mem_ack_i outside REQ is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro defined:
  - A counter increments each REQ cycle without ack and clears on REQ entry.
  - When the count reaches TIMEOUT_CYCLES with no ack: mem_req_o drops, cpu_rdata_o=ERR_DATA (also on a write abort), timeout_o pulses 1 cycle (aligned with DONE), next state DONE.
  - An ack arriving in the same cycle as the limit wins; there is no timeout.
- Without the macro: REQ waits indefinitely, timeout_o is tied to 0, and there is no counter logic.

Test Plan:
- Aligned load: addr=0x10, memread=1; ack with rdata=0x12345678 two cycles after req rises → stall high 3 cycles, then DONE with cpu_rdata_o=0x12345678, stall=0, mem_we_o=0.
- Aligned store: addr=0x20, wdata=0xCAFEF00D, memwrite=1; immediate ack → mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0xCAFEF00D, stall 2 cycles, cpu_rdata_o unchanged.
- Misaligned: addr=0x13, memread=1 → mem_req_o never rises, misalign_o=1 one cycle, stall=0, cpu_rdata_o=0.
- Read+write together, addr=0x8 → treated as write (mem_we_o=1); DONE cycle with memwrite still high → no second transaction.
- Reset mid-REQ: assert rst_i during the 3rd REQ cycle → next edge state IDLE, mem_req_o=0, stall=0; a following ack is ignored.
- DMEM_TIMEOUT_EN defined, no ack → after 16 REQ cycles timeout_o=1, cpu_rdata_o=0xDEADBEEF, stall released; without the macro, stall remains high for 100+ cycles.
